pwm_multimode_core: RTL and testbench
=====================================

Name: pwm_multimode_core

Overview:
Multi-channel PWM generator with a shared prescaler, per-channel edge- or centre-aligned counting, output polarity and channel enable. Period, duty and mode are double-buffered: shadow copies update only at a cycle boundary, so register writes never glitch the output. A per-channel cycle-done pulse drives the AXI4-Lite wrapper's interrupt logic. It is the drop-in successor core behind the existing AXI4-Lite PWM register file.

Parameters:
- NUM_CHANNELS, 4, number of independent PWM channels (1..32).
- REG_WIDTH, 16, width of period, duty and counter (2..32).
- PRESCALER_WIDTH, 16, width of prescale value and counter.

Ports:
- i_clk  in  1  system clock.
- i_resetn  in  1  reset.
- i_enable  in  1  global enable (synchronous).
- i_prescale  in  PRESCALER_WIDTH  tick every i_prescale+1 clocks.
- i_ch_enable  in  NUM_CHANNELS  per-channel enable.
- i_center  in  NUM_CHANNELS  mode: 0 = edge-aligned, 1 = centre-aligned.
- i_polarity  in  NUM_CHANNELS  0 = active-high, 1 = active-low.
- i_period  in  [NUM_CHANNELS-1:0][REG_WIDTH-1:0]  period; element i is channel i.
- i_duty  in  [NUM_CHANNELS-1:0][REG_WIDTH-1:0]  duty; element i is channel i.
- o_pwm  out  NUM_CHANNELS  PWM outputs.
- o_cycle_done  out  NUM_CHANNELS  one-clock pulse at each completed cycle.

Behaviour:
- Reset: i_resetn is asynchronous, active-low; the clock is i_clk.
  - While in reset, the prescale counter, tick, channel counters, direction bits and o_cycle_done are 0.
  - Shadows are 0.
  - o_pwm = 0. Polarity is not applied in reset.
- Prescaler:
  - When i_enable = 0, the prescale counter and tick are held at 0.
  - Otherwise, when cnt >= i_prescale, cnt <= 0 and tick <= 1; else cnt++ and tick <= 0.
  - i_prescale = 0 gives tick high every clock after the first enabled clock.
  - Lowering i_prescale mid-count takes effect immediately via the >= comparison.
- Channel active condition: channel i is active when i_enable = 1 and i_ch_enable[i] = 1.
- Inactive channel:
  - cnt = 0 and dir = up.
  - The shadows (period_sh, duty_sh, center_sh) load from the inputs every clock.
  - o_cycle_done[i] = 0.
- Active channel: state advances only on clocks where tick = 1.
- Edge mode (center_sh = 0):
  - cnt counts 0..P, where P = period_sh, then wraps to 0.
  - Cycle length is P+1 ticks. P = 0 gives cnt fixed at 0, with every tick a wrap.
- Centre mode (center_sh = 1, P >= 1):
  - Count up 0..P, then down P-1..1, then 0. Cycle length is 2P ticks.
  - The direction flips on reaching P (going up) and on reaching 1 (going down).
  - Centre mode with P = 0 behaves as edge mode with P = 0.
- Cycle boundary: the tick on which cnt transitions to 0.
  - On that tick, the shadows load from i_period[i], i_duty[i] and i_center[i].
  - On that tick, o_cycle_done[i] pulses high for exactly one clock.
  - The new values govern counting from cnt = 0 onward.
- Compare: act = (cnt < duty_sh), using unsigned full-width comparison.
  - duty_sh = 0 gives 0%.
  - Edge mode: duty_sh > P gives 100%.
  - Centre mode: active ticks per cycle = 2D-1 for 1 <= D <= P, and 2P (100%) for D > P.
- Output:
  - o_pwm[i] is registered every clock: (active_i & act) ^ i_polarity[i].
  - o_pwm reflects the counter value of the previous clock (one clock of latency).
  - An inactive channel drives i_polarity[i], its idle level.
  - A polarity change takes effect on the next clock without waiting for a boundary.
- Enabling: enabling a channel starts it at cnt = 0 with the shadows already current.
  - The first boundary occurs one full cycle later.
  - No o_cycle_done pulse is generated at enable.
- Disabling:
  - Disabling mid-cycle returns the channel to inactive state on the next clock; the cycle is abandoned.
  - Deasserting i_enable disables all channels and the prescaler on the next clock.
- Reset mid-operation returns all state to reset values immediately, because the reset is asynchronous.
- All widths are unsigned. Counter increments wrap within REG_WIDTH; the counter is bounded by P, so no overflow path exists.

Test Plan:
1. Edge mode, prescale = 0, P = 7, D = 3, polarity 0 → o_pwm 1 for 3 clocks, 0 for 5, repeating with period 8 clocks. o_cycle_done pulses once per 8 clocks, aligned with cnt wrapping 7→0.
2. Centre mode, prescale = 1, P = 4, D = 2 → count sequence 0,1,2,3,4,3,2,1 per tick; o_pwm high 3 of 8 ticks (6 of 16 clocks), the pulse spanning the cnt = 1,0,1 boundary.
3. Shadowing: edge mode, P = 9, D = 2. Write D = 8 when cnt = 4 → remainder of the current cycle unchanged; the next cycle is high for 8 ticks. Same check with P changed 9→3 mid-cycle → the new period applies only after the wrap.
4. Boundaries: D = 0 → constant idle level. Edge mode, D = 8 with P = 7 → constant active. Centre mode, P = 0 → counter stuck at 0 with o_cycle_done every tick. Polarity = 1 inverts all of the above, with an inactive channel driving 1.
5. Enable/reset: drop i_ch_enable[1] mid-cycle → o_pwm[1] goes to idle the next clock while other channels are unaffected. Re-enable → restart from cnt = 0. Assert i_resetn low mid-cycle → outputs 0 asynchronously; after release with enables high, the first tick occurs i_prescale+1 clocks later.

Source files
------------

// File: rtl/pwm_multimode_core.sv
// Multi-channel PWM core with a shared prescaler and per-channel edge/centre-aligned counters.
// Period, duty and mode are shadowed and only reload at a cycle boundary.
module pwm_multimode_core #(
    parameter int unsigned NUM_CHANNELS    = 4,
    parameter int unsigned REG_WIDTH       = 16,
    parameter int unsigned PRESCALER_WIDTH = 16
) (
    input  logic                                    i_clk,
    input  logic                                    i_resetn,
    input  logic                                    i_enable,
    input  logic [PRESCALER_WIDTH-1:0]              i_prescale,
    input  logic [NUM_CHANNELS-1:0]                 i_ch_enable,
    input  logic [NUM_CHANNELS-1:0]                 i_center,
    input  logic [NUM_CHANNELS-1:0]                 i_polarity,
    input  logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0]  i_period,
    input  logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0]  i_duty,
    output logic [NUM_CHANNELS-1:0]                 o_pwm,
    output logic [NUM_CHANNELS-1:0]                 o_cycle_done
);

    typedef enum logic {DirUp, DirDown} dir_e;

    localparam logic [REG_WIDTH-1:0]       One    = REG_WIDTH'(1);
    localparam logic [PRESCALER_WIDTH-1:0] PreOne = PRESCALER_WIDTH'(1);

    logic [PRESCALER_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic                       tick_q, tick_d;

    logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] period_sh_q, period_sh_d;
    logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [NUM_CHANNELS-1:0]                center_sh_q, center_sh_d;
    dir_e                                   dir_q [NUM_CHANNELS];
    dir_e                                   dir_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                active;
    logic [NUM_CHANNELS-1:0]                done_d;
    logic [NUM_CHANNELS-1:0]                pwm_d;

    // Prescaler: the >= compare lets a lowered prescale value take effect mid-count.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        tick_d    = 1'b0;
        if (!i_enable) begin
            pre_cnt_d = '0;
        end else if (pre_cnt_q >= i_prescale) begin
            pre_cnt_d = '0;
            tick_d    = 1'b1;
        end else begin
            pre_cnt_d = pre_cnt_q + PreOne;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cnt_d[i]       = cnt_q[i];
            dir_d[i]       = dir_q[i];
            period_sh_d[i] = period_sh_q[i];
            duty_sh_d[i]   = duty_sh_q[i];
            center_sh_d[i] = center_sh_q[i];
            done_d[i]      = 1'b0;
            active[i]      = i_enable & i_ch_enable[i];

            if (!active[i]) begin
                // Idle channels track the inputs so an enable starts with current settings.
                cnt_d[i]       = '0;
                dir_d[i]       = DirUp;
                period_sh_d[i] = i_period[i];
                duty_sh_d[i]   = i_duty[i];
                center_sh_d[i] = i_center[i];
            end else if (tick_q) begin
                if (!center_sh_q[i] || (period_sh_q[i] == '0)) begin
                    cnt_d[i] = (cnt_q[i] >= period_sh_q[i]) ? '0 : cnt_q[i] + One;
                end else if (dir_q[i] == DirUp) begin
                    if (cnt_q[i] >= period_sh_q[i]) begin
                        if (period_sh_q[i] == One) begin
                            cnt_d[i] = '0;
                        end else begin
                            cnt_d[i] = period_sh_q[i] - One;
                            dir_d[i] = DirDown;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + One;
                    end
                end else begin
                    if (cnt_q[i] <= One) begin
                        cnt_d[i] = '0;
                        dir_d[i] = DirUp;
                    end else begin
                        cnt_d[i] = cnt_q[i] - One;
                    end
                end

                // Cycle boundary: counter returns to zero on this tick.
                if (cnt_d[i] == '0) begin
                    dir_d[i]       = DirUp;
                    period_sh_d[i] = i_period[i];
                    duty_sh_d[i]   = i_duty[i];
                    center_sh_d[i] = i_center[i];
                    done_d[i]      = 1'b1;
                end
            end

            pwm_d[i] = (active[i] & (cnt_q[i] < duty_sh_q[i])) ^ i_polarity[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            cnt_q        <= '0;
            period_sh_q  <= '0;
            duty_sh_q    <= '0;
            center_sh_q  <= '0;
            o_pwm        <= '0;
            o_cycle_done <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                dir_q[i] <= DirUp;
            end
        end else begin
            cnt_q        <= cnt_d;
            period_sh_q  <= period_sh_d;
            duty_sh_q    <= duty_sh_d;
            center_sh_q  <= center_sh_d;
            o_pwm        <= pwm_d;
            o_cycle_done <= done_d;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                dir_q[i] <= dir_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multimode_core.sv
// Directed bench for pwm_multimode_core: hand-computed output/cycle-done patterns per scenario.
// Pattern vectors are LSB-first: bit k-1 is the value expected k clocks after the reference edge.
module tb_pwm_multimode_core;

    localparam int NC = 4;
    localparam int RW = 16;
    localparam int PW = 16;

    logic                   clk    = 1'b0;
    logic                   resetn = 1'b0;
    logic                   en     = 1'b0;
    logic [PW-1:0]          prescale = '0;
    logic [NC-1:0]          ch_en  = '0;
    logic [NC-1:0]          center = '0;
    logic [NC-1:0]          pol    = '0;
    logic [NC-1:0][RW-1:0]  period = '0;
    logic [NC-1:0][RW-1:0]  duty   = '0;
    logic [NC-1:0]          pwm;
    logic [NC-1:0]          done;

    int tests = 0;
    int fails = 0;

    pwm_multimode_core #(
        .NUM_CHANNELS    (NC),
        .REG_WIDTH       (RW),
        .PRESCALER_WIDTH (PW)
    ) dut (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .i_enable     (en),
        .i_prescale   (prescale),
        .i_ch_enable  (ch_en),
        .i_center     (center),
        .i_polarity   (pol),
        .i_period     (period),
        .i_duty       (duty),
        .o_pwm        (pwm),
        .o_cycle_done (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic window(input string tag, input int ch, input int n,
                          input logic [31:0] exp_pwm, input logic [31:0] exp_done);
        for (int k = 0; k < n; k++) begin
            step();
            check($sformatf("%s pwm[%0d] k=%0d", tag, ch, k + 1), 32'(pwm[ch]), 32'(exp_pwm[k]));
            check($sformatf("%s done[%0d] k=%0d", tag, ch, k + 1), 32'(done[ch]),
                  32'(exp_done[k]));
        end
    endtask

    task automatic wait_done(input string tag, input int ch);
        int n = 0;
        while (done[ch] !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({tag, " sync"}, 32'(done[ch]), 32'd1);
    endtask

    initial begin
        // Reset: outputs 0 even with polarity and enables set
        en     = 1'b1;
        ch_en  = 4'b1111;
        pol    = 4'b1010;
        step();
        step();
        check("reset pwm", 32'(pwm), 32'h0);
        check("reset done", 32'(done), 32'h0);

        ch_en  = '0;
        pol    = '0;
        resetn = 1'b1;

        // 1: edge mode, prescale 0, P=7, D=3
        period[0] = 16'd7;
        duty[0]   = 16'd3;
        step();
        step();
        step();
        ch_en = 4'b0001;
        window("t1 edge", 0, 16, 32'h0707, 32'h8080);
        check("t1 others idle", 32'(pwm[3:1]), 32'h0);

        // 2: centre mode, prescale 1, P=4, D=2
        ch_en     = '0;
        prescale  = 16'd1;
        center[1] = 1'b1;
        period[1] = 16'd4;
        duty[1]   = 16'd2;
        step();
        step();
        ch_en = 4'b0010;
        wait_done("t2 centre", 1);
        check("t2 boundary pwm", 32'(pwm[1]), 32'd1);
        window("t2 centre", 1, 16, 32'hC00F, 32'h8000);

        // 3: shadowing of duty, then of period
        ch_en     = '0;
        prescale  = '0;
        center    = '0;
        period[2] = 16'd9;
        duty[2]   = 16'd2;
        step();
        step();
        ch_en = 4'b0100;
        wait_done("t3 shadow", 2);
        window("t3a", 2, 4, 32'h3, 32'h0);
        duty[2] = 16'd8;
        window("t3b", 2, 16, 32'h3FC0, 32'h8020);
        window("t3c", 2, 4, 32'hF, 32'h0);
        period[2] = 16'd3;
        duty[2]   = 16'd2;
        window("t3d", 2, 14, 32'h0CCF, 32'h2220);

        // 4: boundaries - D=0, D>P, centre P=0, then polarity inverted
        ch_en     = '0;
        period[0] = 16'd7;
        duty[0]   = 16'd0;
        period[1] = 16'd7;
        duty[1]   = 16'd8;
        period[2] = 16'd0;
        duty[2]   = 16'd1;
        center    = 4'b0100;
        step();
        step();
        ch_en = 4'b0111;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("t4 pwm k=%0d", k), 32'(pwm), 32'h6);
            check($sformatf("t4 p0 done k=%0d", k), 32'(done[2]), 32'd1);
        end
        pol = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("t4 inv pwm k=%0d", k), 32'(pwm), 32'h9);
        end

        // 5: channel disable/re-enable, then asynchronous reset
        pol       = '0;
        ch_en     = '0;
        center    = '0;
        period[0] = 16'd7;
        duty[0]   = 16'd3;
        period[1] = 16'd7;
        duty[1]   = 16'd3;
        step();
        step();
        ch_en = 4'b0011;
        wait_done("t5 sync", 1);
        for (int k = 1; k <= 2; k++) begin
            step();
            check($sformatf("t5 both k=%0d", k), 32'(pwm[1:0]), 32'h3);
        end
        ch_en = 4'b0001;
        for (int k = 3; k <= 8; k++) begin
            step();
            check($sformatf("t5 ch0 pwm k=%0d", k), 32'(pwm[0]), 32'(k == 3));
            check($sformatf("t5 ch1 idle k=%0d", k), 32'(pwm[1]), 32'd0);
            check($sformatf("t5 ch1 done k=%0d", k), 32'(done[1]), 32'd0);
            check($sformatf("t5 ch0 done k=%0d", k), 32'(done[0]), 32'(k == 8));
        end
        ch_en = 4'b0011;
        window("t5 restart", 1, 8, 32'h07, 32'h80);

        pol[3] = 1'b1;
        step();
        check("t5 pre-reset idle", 32'(pwm[3]), 32'd1);
        prescale = 16'd2;
        #3;
        resetn = 1'b0;
        #1;
        check("t5 async pwm", 32'(pwm), 32'h0);
        check("t5 async done", 32'(done), 32'h0);
        step();
        step();
        resetn = 1'b1;
        begin
            int n = 0;
            while (n < 50) begin
                step();
                n++;
                if (done[0] === 1'b1) break;
            end
            // Tick lands prescale+1 clocks after release; done registers one clock later.
            check("t5 first tick", 32'(n), 32'd4);
        end
        step();
        check("t5 done single", 32'(done[0]), 32'd0);

        en = 1'b0;
        step();
        check("global disable pwm", 32'(pwm), 32'h8);
        check("global disable done", 32'(done), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
